als_sample_scheduler: RTL and testbench
=======================================

// Module: als_sample_scheduler
// PURPOSE
//  Sequences the SPI ambient-light-sensor read in lightpwm: periodic or on-demand trigger,
//  drives ncs/sck, shifts in one 16-bit frame from sdo, checks framing, and publishes the
//  8-bit light sample (frame bits [11:4]) to the PWM duty logic. Sole master of the sensor bus.
// PARAMETERS
//  CLK_DIV        8       clk cycles per sck half-period; legal range >= 2
//  SAMPLE_PERIOD  100000  clk cycles between periodic triggers; legal range > 34*CLK_DIV
// PORTS
//  clk           in   1  system clock, all logic on posedge
//  rst           in   1  asynchronous, active-high reset
//  enable        in   1  1 = periodic triggering active
//  start         in   1  1-cycle pulse: request one frame now
//  ncs           out  1  sensor chip select, active low
//  sck           out  1  sensor serial clock, idles high
//  sdo           in   1  sensor data; sensor shifts it on sck falling edge
//  sample        out  8  last accepted light value
//  sample_valid  out  1  1-cycle pulse when sample updates
//  frame_err     out  1  1-cycle pulse (with sample_valid timing) on bad framing
//  busy          out  1  1 while ncs low or in quiet time
// BEHAVIOUR
//  Reset (async): ncs=1, sck=1, sample=0, sample_valid=0, frame_err=0, busy=0, FSM=IDLE,
//   period counter=0, pending=0.
//  Trigger: period counter counts while enable=1, fires at SAMPLE_PERIOD-1 then wraps to 0;
//   enable=0 holds counter at 0. Trigger = tick | start. Trigger outside IDLE sets pending
//   (1 deep); further triggers while pending=1 are dropped. IDLE with pending launches next.
//  FSM: IDLE -> SETUP -> {LOW -> HIGH} x16 -> QUIET -> IDLE.
//   IDLE: ncs=1, sck=1. Trigger registered at cycle T => ncs falls at T+1.
//   SETUP: ncs=0, sck=1 for CLK_DIV cycles; last cycle samples sdo as bit 15.
//   LOW: sck=0 for CLK_DIV cycles. HIGH: sck=1 for CLK_DIV cycles; last cycle of HIGH
//    phases 1..15 samples sdo as bits 14..0; HIGH phase 16 samples nothing.
//   ncs low exactly 33*CLK_DIV cycles. QUIET: ncs=1, sck=1 for CLK_DIV cycles.
//  Publish: first cycle of QUIET (ncs just high): if frame[15:12]==0 and frame[3:0]==0,
//   sample<=frame[11:4], sample_valid=1; else frame_err=1, sample_valid=0, sample unchanged.
//  Trigger->sample_valid latency = 1 + 33*CLK_DIV cycles.
//  enable falling mid-frame: frame completes and publishes; pending is kept.
//  start coincident with tick: one request only.
//  Reset mid-frame: ncs/sck return high immediately; the partial frame is discarded.
// CONFIGURATION
//  ALS_AVERAGE_EN defined: sample = (sum of last 4 accepted values) >> 2, 10-bit sum.
//   Bad frames are excluded from the window. The first accepted value after reset preloads
//   all 4 window entries. Latency is unchanged.
//  ALS_AVERAGE_EN undefined: sample = the raw frame[11:4]; no window registers.
// STRUCTURE
//  Package als_pkg: ALS_FRAME_W=16, ALS_DATA_MSB=11, ALS_DATA_LSB=4, ALS_NIBBLE_ZERO masks,
//   FSM state enum (IDLE, SETUP, LOW, HIGH, QUIET), bit-counter width.
//  One sub-module: als_phase_timer, a CLK_DIV down-counter that emits a last-cycle strobe and
//   is reloaded on every state entry. The FSM, shifter, pending logic and averager sit in the
//   top module.
// TESTING (sensor model: shifts on falling sck, reloads frame while ncs=1; CLK_DIV=4)
//  1 start, frame 0x0A50 -> ncs low 132 cycles, 16 sck falls, sample=0xA5, sample_valid
//    pulse at ncs rise, frame_err=0.
//  2 frame 0x8A50 and then 0x0A5F -> frame_err pulse each time, no sample_valid,
//    sample stays 0xA5.
//  3 enable=1, SAMPLE_PERIOD=200 -> ncs falls every 200 cycles; start and tick issued
//    mid-frame -> exactly one extra frame after QUIET.
//  4 rst asserted at bit 7 of a frame -> ncs=1, sck=1 same cycle, no sample_valid; the
//    next start gives a clean frame.
//  5 ALS_AVERAGE_EN, frames 0x0100/0x0200/0x0300/0x0400 -> sample 0x10, 0x14, 0x1C, 0x28.
//  6 start held on two consecutive cycles in IDLE -> one frame then one pending frame;
//    never more than 2 frames.

Source files
------------

// File: rtl/als_pkg.sv
// Shared constants, FSM state encoding and framing helper for the ALS sample scheduler.
package als_pkg;

  localparam int ALS_FRAME_W   = 16;
  localparam int ALS_DATA_MSB  = 11;
  localparam int ALS_DATA_LSB  = 4;
  localparam int ALS_DATA_W    = ALS_DATA_MSB - ALS_DATA_LSB + 1;
  localparam int ALS_BIT_CNT_W = $clog2(ALS_FRAME_W);

  // Frame bits that must read back as zero: the top and bottom nibbles.
  localparam logic [ALS_FRAME_W-1:0] ALS_NIBBLE_ZERO_HI = 16'hF000;
  localparam logic [ALS_FRAME_W-1:0] ALS_NIBBLE_ZERO_LO = 16'h000F;
  localparam logic [ALS_FRAME_W-1:0] ALS_NIBBLE_ZERO    = ALS_NIBBLE_ZERO_HI | ALS_NIBBLE_ZERO_LO;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOW,
    HIGH,
    QUIET
  } als_state_e;

  function automatic logic als_frame_ok(input logic [ALS_FRAME_W-1:0] frame);
    return (frame & ALS_NIBBLE_ZERO) == '0;
  endfunction

endpackage

// File: rtl/als_sample_scheduler_if.sv
// Three-wire sensor bus between the scheduler (master) and the light sensor (slave).
interface als_sample_scheduler_if;
  logic ncs;
  logic sck;
  logic sdo;

  modport master (output ncs, output sck, input sdo);
  modport slave  (input ncs, input sck, output sdo);
endinterface

// File: rtl/als_phase_timer.sv
// CLK_DIV-cycle phase timer: reloads on every FSM state entry, strobes on the phase's last cycle.
module als_phase_timer #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic last
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(CLK_DIV - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == '0);

endmodule

// File: rtl/als_sample_scheduler.sv
// Ambient-light-sensor frame reader: periodic/on-demand trigger, SPI sequencing, framing check.
// Define ALS_AVERAGE_EN to publish a 4-sample running average instead of the raw value.
module als_sample_scheduler
  import als_pkg::*;
#(
  parameter int CLK_DIV       = 8,
  parameter int SAMPLE_PERIOD = 100000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      start,
  als_sample_scheduler_if.master    spi,
  output logic [ALS_DATA_W-1:0]     sample,
  output logic                      sample_valid,
  output logic                      frame_err,
  output logic                      busy
);

  localparam int PW = $clog2(SAMPLE_PERIOD);

  als_state_e               state_q, state_d;
  logic [PW-1:0]            per_cnt_q, per_cnt_d;
  logic                     pending_q, pending_d;
  logic [ALS_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [ALS_FRAME_W-1:0]   shift_q, shift_d;
  logic [ALS_DATA_W-1:0]    sample_q, sample_d;
  logic                     sample_valid_q, sample_valid_d;
  logic                     frame_err_q, frame_err_d;

  logic tick, trigger, launch, phase_last, frame_ok, accept;
  logic [ALS_DATA_W-1:0] data;

  assign tick     = enable && (per_cnt_q == PW'(SAMPLE_PERIOD - 1));
  assign trigger  = tick | start;
  assign launch   = trigger | pending_q;
  assign frame_ok = als_frame_ok(shift_q);
  assign data     = shift_q[ALS_DATA_MSB:ALS_DATA_LSB];

  always_comb begin
    per_cnt_d = per_cnt_q + 1'b1;
    if (!enable || tick) begin
      per_cnt_d = '0;
    end
  end

  als_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (state_d != state_q),
    .last (phase_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (launch)     state_d = SETUP;
      SETUP:   if (phase_last) state_d = LOW;
      LOW:     if (phase_last) state_d = HIGH;
      HIGH:    if (phase_last) state_d = (bit_cnt_q == '1) ? QUIET : LOW;
      QUIET:   if (phase_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    spi.ncs = 1'b1;
    spi.sck = 1'b1;
    busy    = (state_q != IDLE);
    unique case (state_q)
      SETUP:   spi.ncs = 1'b0;
      LOW:     begin spi.ncs = 1'b0; spi.sck = 1'b0; end
      HIGH:    spi.ncs = 1'b0;
      default: ;
    endcase
  end

  // HIGH phase 16 (bit_cnt_q == 15) samples nothing; its end is the publish point.
  always_comb begin
    pending_d      = pending_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    sample_valid_d = 1'b0;
    frame_err_d    = 1'b0;
    accept         = 1'b0;
    if (state_q == IDLE) begin
      if (launch) begin
        pending_d = 1'b0;
        bit_cnt_d = '0;
      end
    end else if (trigger) begin
      pending_d = 1'b1;
    end
    if (phase_last) begin
      case (state_q)
        SETUP: shift_d = {shift_q[ALS_FRAME_W-2:0], spi.sdo};
        HIGH: begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q != '1) begin
            shift_d = {shift_q[ALS_FRAME_W-2:0], spi.sdo};
          end else begin
            accept         = frame_ok;
            sample_valid_d = frame_ok;
            frame_err_d    = !frame_ok;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALS_AVERAGE_EN
  localparam int SUM_W = ALS_DATA_W + 2;

  logic [3:0][ALS_DATA_W-1:0] win_q, win_d;
  logic                       primed_q, primed_d;
  logic [SUM_W-1:0]           win_sum;

  // win[3] holds the newest value; the first accepted value fills every slot.
  always_comb begin
    win_d    = win_q;
    primed_d = primed_q | accept;
    if (accept) begin
      win_d[3] = data;
      for (int i = 0; i < 3; i++) begin
        win_d[i] = primed_q ? win_q[i+1] : data;
      end
    end
  end

  assign win_sum  = SUM_W'(win_d[0]) + SUM_W'(win_d[1]) + SUM_W'(win_d[2]) + SUM_W'(win_d[3]);
  assign sample_d = accept ? win_sum[SUM_W-1:2] : sample_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q    <= '0;
      primed_q <= 1'b0;
    end else begin
      win_q    <= win_d;
      primed_q <= primed_d;
    end
  end
`else
  assign sample_d = accept ? data : sample_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt_q      <= '0;
      pending_q      <= 1'b0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      per_cnt_q      <= per_cnt_d;
      pending_q      <= pending_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      frame_err_q    <= frame_err_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_als_sample_scheduler.sv
// Directed bench for als_sample_scheduler with a falling-edge-shifting sensor model, CLK_DIV=4.
module tb_als_sample_scheduler;

  localparam int CLK_DIV    = 4;
  localparam int PERIOD     = 200;
  localparam int LOW_CYCLES = 33 * CLK_DIV;
  localparam int LATENCY    = 1 + 33 * CLK_DIV;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       start;
  logic [7:0] sample;
  logic       sample_valid;
  logic       frame_err;
  logic       busy;

  als_sample_scheduler_if spi ();

  als_sample_scheduler #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(PERIOD)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .start        (start),
    .spi          (spi),
    .sample       (sample),
    .sample_valid (sample_valid),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sensor: loads its frame when ncs falls (sck high), shifts on every sck fall after that.
  logic [15:0] sens_frame;
  logic [15:0] sens_sh;
  always @(negedge spi.sck or negedge spi.ncs) begin
    if (spi.sck) sens_sh <= sens_frame;
    else         sens_sh <= {sens_sh[14:0], 1'b0};
  end
  assign spi.sdo = sens_sh[15];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_fall = 0, n_sv = 0, n_fe = 0, n_sckfall = 0;
  int   low_cnt = 0, last_low = 0, last_fall_cyc = 0, fall_gap = 0, sv_cyc = 0;
  logic prev_ncs = 1'b1, prev_sck = 1'b1;
  logic sv_at_rise = 1'b0, fe_at_rise = 1'b0, busy_at_sv = 1'b0;

  always @(negedge clk) begin
    if (prev_ncs && !spi.ncs) begin
      n_fall        <= n_fall + 1;
      fall_gap      <= cyc - last_fall_cyc;
      last_fall_cyc <= cyc;
      low_cnt       <= 1;
    end else if (!spi.ncs) begin
      low_cnt <= low_cnt + 1;
    end
    if (!prev_ncs && spi.ncs) last_low <= low_cnt;
    if (prev_sck && !spi.sck && !spi.ncs) n_sckfall <= n_sckfall + 1;
    if (sample_valid) begin
      n_sv       <= n_sv + 1;
      sv_cyc     <= cyc;
      sv_at_rise <= !prev_ncs && spi.ncs;
      busy_at_sv <= busy;
    end
    if (frame_err) begin
      n_fe       <= n_fe + 1;
      fe_at_rise <= !prev_ncs && spi.ncs;
    end
    prev_ncs <= spi.ncs;
    prev_sck <= spi.sck;
  end

  int checks   = 0;
  int failures = 0;
  int start_cyc = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int base);
    int k = 0;
    while ((n_sv + n_fe) == base && k < 400) begin
      @(negedge clk);
      k++;
    end
    check_val(tag, 32'((n_sv + n_fe) != base), 1);
  endtask

  task automatic wait_idle(input string tag);
    int quiet = 0;
    int k = 0;
    while (quiet < 10 && k < 3000) begin
      @(negedge clk);
      k++;
      quiet = busy ? 0 : quiet + 1;
    end
    check_val(tag, 32'(quiet >= 10), 1);
  endtask

  task automatic wait_fall(input string tag, input int base);
    int k = 0;
    while (n_fall == base && k < 300) begin
      @(negedge clk);
      k++;
    end
    check_val(tag, 32'(n_fall != base), 1);
  endtask

  task automatic run_frame(input string tag, input logic [15:0] frame);
    int b;
    sens_frame = frame;
    b = n_sv + n_fe;
    pulse_start();
    wait_result(tag, b);
    wait_idle(tag);
  endtask

  int b_sv, b_fe, b_sf, b_fall;

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    start      = 1'b0;
    sens_frame = 16'h0A50;
    repeat (3) @(negedge clk);
    check_val("rst_ncs", 32'(spi.ncs), 1);
    check_val("rst_sck", 32'(spi.sck), 1);
    check_val("rst_sample", 32'(sample), 0);
    check_val("rst_valid", 32'(sample_valid), 0);
    check_val("rst_err", 32'(frame_err), 0);
    check_val("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: good frame 0x0A50 -> 0xA5
    b_sv = n_sv; b_fe = n_fe; b_sf = n_sckfall;
    run_frame("t1_done", 16'h0A50);
    check_val("t1_latency", 32'(sv_cyc - start_cyc), LATENCY);
    check_val("t1_ncs_low", 32'(last_low), LOW_CYCLES);
    check_val("t1_sck_falls", 32'(n_sckfall - b_sf), 16);
    check_val("t1_sample", 32'(sample), 32'h0A5);
    check_val("t1_valid_cnt", 32'(n_sv - b_sv), 1);
    check_val("t1_err_cnt", 32'(n_fe - b_fe), 0);
    check_val("t1_valid_at_ncs_rise", 32'(sv_at_rise), 1);
    check_val("t1_busy_in_quiet", 32'(busy_at_sv), 1);

    // 2: bad top nibble, then bad bottom nibble
    b_sv = n_sv; b_fe = n_fe;
    run_frame("t2a_done", 16'h8A50);
    check_val("t2a_err_cnt", 32'(n_fe - b_fe), 1);
    check_val("t2a_err_at_ncs_rise", 32'(fe_at_rise), 1);
    check_val("t2a_sample", 32'(sample), 32'h0A5);
    run_frame("t2b_done", 16'h0A5F);
    check_val("t2b_err_cnt", 32'(n_fe - b_fe), 2);
    check_val("t2b_valid_cnt", 32'(n_sv - b_sv), 0);
    check_val("t2b_sample", 32'(sample), 32'h0A5);

    // 6: start held two cycles in IDLE -> exactly two frames
    sens_frame = 16'h0A50;
    b_fall = n_fall; b_sv = n_sv;
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_idle("t6_idle");
    check_val("t6_frames", 32'(n_fall - b_fall), 2);
    check_val("t6_valid_cnt", 32'(n_sv - b_sv), 2);

    // 3: periodic triggering, then start+tick mid-frame give one extra frame
    b_fall = n_fall;
    enable = 1'b1;
    wait_fall("t3_first_fall", b_fall);
    wait_fall("t3_second_fall", b_fall + 1);
    check_val("t3_period", 32'(fall_gap), PERIOD);
    b_fall = n_fall; b_sv = n_sv;
    repeat (148) @(negedge clk);
    pulse_start();
    repeat (20) @(negedge clk);
    pulse_start();
    repeat (130) @(negedge clk);
    enable = 1'b0;
    wait_idle("t3_idle");
    check_val("t3_frames_after_tick", 32'(n_fall - b_fall), 2);
    check_val("t3_valid_cnt", 32'(n_sv - b_sv), 3);

    // 4: asynchronous reset around bit 7 discards the frame
    b_sv = n_sv; b_fe = n_fe; b_sf = n_sckfall;
    sens_frame = 16'h0A50;
    pulse_start();
    begin
      int k = 0;
      while ((n_sckfall - b_sf) < 8 && k < 200) begin
        @(negedge clk);
        k++;
      end
      check_val("t4_reach_bit7", 32'((n_sckfall - b_sf) >= 8), 1);
    end
    #2 rst = 1'b1;
    #1;
    check_val("t4_ncs_high", 32'(spi.ncs), 1);
    check_val("t4_sck_high", 32'(spi.sck), 1);
    check_val("t4_busy", 32'(busy), 0);
    check_val("t4_sample", 32'(sample), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check_val("t4_no_valid", 32'(n_sv - b_sv), 0);
    check_val("t4_no_err", 32'(n_fe - b_fe), 0);
    run_frame("t4_clean_done", 16'h0A50);
    check_val("t4_clean_sample", 32'(sample), 32'h0A5);
    check_val("t4_clean_ncs_low", 32'(last_low), LOW_CYCLES);

`ifdef ALS_AVERAGE_EN
    // 5: running average over the last four accepted values
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_frame("t5a_done", 16'h0100);
    check_val("t5a_avg", 32'(sample), 32'h10);
    run_frame("t5b_done", 16'h0200);
    check_val("t5b_avg", 32'(sample), 32'h14);
    run_frame("t5c_done", 16'h0300);
    check_val("t5c_avg", 32'(sample), 32'h1C);
    run_frame("t5d_done", 16'h0400);
    check_val("t5d_avg", 32'(sample), 32'h28);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
